// File: rtl/clock_cfg_seq.sv
// Configuration sequencer for the CLOCK block: loads a frequency request, pulses
// CLOCK's reset, waits for a stable lock and retries with a stepped init on timeout.
module clock_cfg_seq #(
    parameter logic [2:0] LOCK_CODE     = 3'b001,
    parameter int         RST_CYCLES    = 4,
    parameter int         TIMEOUT       = 1000000,
    parameter int         STABLE_CYCLES = 16,
    parameter int         MAX_RETRY     = 3,
    parameter logic [8:0] INIT_STEP     = 9'd64
) (
    input  logic        ref_clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_init,
    input  logic [15:0] req_counter,
    input  logic [15:0] req_ref_counter,
    output logic        clk_resetn,
    output logic [8:0]  init,
    output logic [15:0] counter,
    output logic [15:0] ref_counter,
    input  logic [2:0]  status,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        fail,
    output logic        lock_lost,
    output logic [2:0]  retries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOCK,
        S_CONFIRM,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam logic [7:0]  RST_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [23:0] TIMER_LAST  = 24'(TIMEOUT - 1);
    localparam logic [7:0]  STABLE_CNT  = 8'(STABLE_CYCLES);
    localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state_q;
    logic [2:0]  status_meta_q;
    logic [2:0]  status_s_q;
    logic [7:0]  rst_cnt_q;
    logic [23:0] timer_q;
    logic [7:0]  stable_q;
    logic        lost_q;
    logic        clk_resetn_q;
    logic        busy_q;
    logic        locked_q;
    logic        done_q;
    logic        fail_q;
    logic        lock_lost_q;
    logic [2:0]  retries_q;
    logic [8:0]  init_q;
    logic [15:0] counter_q;
    logic [15:0] ref_counter_q;

    logic        accept;
    logic        lock_seen;
    logic        timer_expired;
    logic [8:0]  init_stepped;
    logic [7:0]  stable_inc;
    logic        stable_reached;

    assign req_ready      = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_FAIL);
    assign accept         = req_valid && req_ready;
    assign lock_seen      = (status_s_q == LOCK_CODE);
    assign timer_expired  = (timer_q == TIMER_LAST);
    assign init_stepped   = init_q + INIT_STEP;
    // The cycle that first sees lock in WAIT_LOCK already counts as one stable cycle.
    assign stable_inc     = (state_q == S_CONFIRM) ? stable_q + 8'd1 : 8'd1;
    assign stable_reached = (stable_inc == STABLE_CNT);

    assign clk_resetn  = clk_resetn_q;
    assign init        = init_q;
    assign counter     = counter_q;
    assign ref_counter = ref_counter_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign lock_lost   = lock_lost_q;
    assign retries     = retries_q;

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            status_meta_q <= 3'd0;
            status_s_q    <= 3'd0;
        end else begin
            status_meta_q <= status;
            status_s_q    <= status_meta_q;
        end
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= 8'd0;
            timer_q       <= 24'd0;
            stable_q      <= 8'd0;
            lost_q        <= 1'b0;
            clk_resetn_q  <= 1'b0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            lock_lost_q   <= 1'b0;
            retries_q     <= 3'd0;
            init_q        <= 9'd0;
            counter_q     <= 16'd0;
            ref_counter_q <= 16'd0;
        end else begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOCKED, S_FAIL: begin
                    if (accept) begin
                        init_q        <= req_init;
                        counter_q     <= req_counter;
                        ref_counter_q <= req_ref_counter;
                        retries_q     <= 3'd0;
                        locked_q      <= 1'b0;
                        clk_resetn_q  <= 1'b0;
                        busy_q        <= 1'b1;
                        rst_cnt_q     <= 8'd0;
                        lost_q        <= 1'b0;
                        state_q       <= S_LOAD;
                    end else if (state_q == S_LOCKED) begin
                        // Two consecutive misses are needed; a single-cycle glitch only arms lost_q.
                        if (!lock_seen) begin
                            if (lost_q) begin
                                lock_lost_q  <= 1'b1;
                                locked_q     <= 1'b0;
                                retries_q    <= 3'd0;
                                clk_resetn_q <= 1'b0;
                                busy_q       <= 1'b1;
                                rst_cnt_q    <= 8'd0;
                                lost_q       <= 1'b0;
                                state_q      <= S_LOAD;
                            end else begin
                                lost_q <= 1'b1;
                            end
                        end else begin
                            lost_q <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        clk_resetn_q <= 1'b1;
                        timer_q      <= 24'd0;
                        stable_q     <= 8'd0;
                        state_q      <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 8'd1;
                    end
                end

                S_WAIT_LOCK, S_CONFIRM: begin
                    if (timer_expired) begin
                        clk_resetn_q <= 1'b0;
                        stable_q     <= 8'd0;
                        if (retries_q == RETRY_LIMIT) begin
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FAIL;
                        end else begin
                            init_q    <= init_stepped;
                            retries_q <= retries_q + 3'd1;
                            rst_cnt_q <= 8'd0;
                            state_q   <= S_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q + 24'd1;
                        if (!lock_seen) begin
                            stable_q <= 8'd0;
                            state_q  <= S_WAIT_LOCK;
                        end else if (stable_reached) begin
                            done_q   <= 1'b1;
                            locked_q <= 1'b1;
                            busy_q   <= 1'b0;
                            lost_q   <= 1'b0;
                            stable_q <= 8'd0;
                            state_q  <= S_LOCKED;
                        end else begin
                            stable_q <= stable_inc;
                            state_q  <= S_CONFIRM;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_cfg_seq.sv
// Self-checking bench for clock_cfg_seq: table of request scenarios with a result
// scoreboard, plus hand-written lock-loss, held-request and async-reset sequences.
module tb_clock_cfg_seq;

    localparam logic [2:0] LOCK = 3'b001;
    localparam int         RST  = 4;

    logic        ref_clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_init;
    logic [15:0] req_counter;
    logic [15:0] req_ref_counter;
    logic        clk_resetn;
    logic [8:0]  init;
    logic [15:0] counter;
    logic [15:0] ref_counter;
    logic [2:0]  status;
    logic        busy;
    logic        locked;
    logic        done;
    logic        fail;
    logic        lock_lost;
    logic [2:0]  retries;

    always #5 ref_clk = ~ref_clk;

    clock_cfg_seq #(
        .LOCK_CODE    (LOCK),
        .RST_CYCLES   (RST),
        .TIMEOUT      (100),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2),
        .INIT_STEP    (9'd64)
    ) dut (
        .ref_clk        (ref_clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_init       (req_init),
        .req_counter    (req_counter),
        .req_ref_counter(req_ref_counter),
        .clk_resetn     (clk_resetn),
        .init           (init),
        .counter        (counter),
        .ref_counter    (ref_counter),
        .status         (status),
        .busy           (busy),
        .locked         (locked),
        .done           (done),
        .fail           (fail),
        .lock_lost      (lock_lost),
        .retries        (retries)
    );

    // lock_att: attempt index whose status goes to LOCK (7 = never);
    // lock_at/glitch_at: cycles after clk_resetn rises (glitch_at = one low cycle, -1 none).
    typedef struct {
        logic [8:0]  init;
        logic [15:0] cnt;
        logic [15:0] rcnt;
        int          lock_att;
        int          lock_at;
        int          glitch_at;
        bit          hold;
        bit          exp_done;
        int          exp_retries;
        logic [8:0]  exp_init;
        int          exp_done_at;
    } vec_t;

    typedef struct {
        bit          done;
        int          retries;
        logic [8:0]  init;
        logic [15:0] cnt;
        logic [15:0] rcnt;
        int          done_at;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick;
        @(negedge ref_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {req_ready, clk_resetn, busy, locked, done, fail, lock_lost, retries},
              10'b1000000000);
        check({tag, "_cfg"}, {init, counter, ref_counter}, 41'd0);
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.done    = v.exp_done;
        e.retries = v.exp_retries;
        e.init    = v.exp_init;
        e.cnt     = v.cnt;
        e.rcnt    = v.rcnt;
        e.done_at = v.exp_done_at;
        sb_q.push_back(e);
    endtask

    task automatic send_req(input logic [8:0] i, input logic [15:0] c, input logic [15:0] r);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick;
            n++;
        end
        check("req_ready_before_send", req_ready, 1);
        req_valid       = 1'b1;
        req_init        = i;
        req_counter     = c;
        req_ref_counter = r;
        tick;
        req_valid = 1'b0;
        check("accept_state", {clk_resetn, busy, locked, req_ready}, 4'b0100);
        check("accept_capture", {init, counter, ref_counter}, {i, c, r});
        check("accept_retries", retries, 0);
    endtask

    // Starts on the first LOAD cycle; drives status per attempt until done or fail.
    task automatic monitor(input vec_t v);
        exp_t       e;
        bit         prev_rn;
        bit         ended;
        int         low_cnt;
        int         att;
        int         since;
        int         n;
        logic [8:0] ei;
        prev_rn = 1'b0;
        ended   = 1'b0;
        low_cnt = 0;
        att     = 0;
        since   = -1;
        n       = 0;
        while (!ended && n < 1500) begin
            if (clk_resetn) begin
                if (!prev_rn) begin
                    ei = v.init + 9'(64 * att);
                    check("load_low_cycles", low_cnt, RST);
                    check("attempt_init", init, ei);
                    check("attempt_busy", busy, 1);
                    since = 0;
                end else begin
                    since++;
                end
            end else begin
                if (prev_rn) begin
                    att++;
                    low_cnt = 0;
                end
                low_cnt++;
                since = -1;
            end
            if (done || fail) begin
                ended = 1'b1;
            end else begin
                status = (clk_resetn && att == v.lock_att && since >= v.lock_at && since != v.glitch_at)
                         ? LOCK : 3'b000;
                if (v.hold && clk_resetn) begin
                    req_valid       = 1'b1;
                    req_init        = 9'd5;
                    req_counter     = 16'hBEEF;
                    req_ref_counter = 16'h0101;
                end
                prev_rn = clk_resetn;
                tick;
                n++;
            end
        end
        check("completion_bound", ended, 1);
        if (!ended) return;
        check("scoreboard_depth", sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("outcome_pulses", {done, fail, lock_lost}, {e.done, !e.done, 1'b0});
        check("outcome_retries", retries, e.retries);
        check("outcome_init", init, e.init);
        check("outcome_counters", {counter, ref_counter}, {e.cnt, e.rcnt});
        check("outcome_state", {locked, busy, req_ready, clk_resetn}, {e.done, 1'b0, 1'b1, e.done});
        if (e.done) check("done_latency", since, e.done_at);
        $display("txn init=%0d cnt=%04h ref=%04h -> %s retries=%0d final_init=%0d",
                 v.init, v.cnt, v.rcnt, done ? "done" : "fail", retries, init);
        tick;
        check("pulse_single", {done, fail}, 2'b00);
        if (v.hold) begin
            check("held_req_accepted", {init, counter, ref_counter}, {9'd5, 16'hBEEF, 16'h0101});
            check("held_req_state", {clk_resetn, busy, locked, retries}, 6'b010000);
            req_valid = 1'b0;
        end else begin
            check("post_outcome_locked", locked, e.done);
        end
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v);
        send_req(v.init, v.cnt, v.rcnt);
        monitor(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       rv;
        logic [8:0] last_init;
        int         lost_seen;
        int         unlocked;
        int         n;

        //           init    cnt       rcnt      att at  glt hold done rtr exp_init done_at
        vecs[0] = '{9'd100, 16'h1234, 16'h0400, 0, 10, -1, 1'b0, 1'b1, 0, 9'd100, 20};
        vecs[1] = '{9'd480, 16'h5555, 16'h0200, 7, 0,  -1, 1'b0, 1'b0, 2, 9'd96,  -1};
        vecs[2] = '{9'd200, 16'h0A0A, 16'h0300, 0, 20, 25, 1'b0, 1'b1, 0, 9'd200, 36};
        vecs[3] = '{9'd10,  16'h00FF, 16'h0010, 0, 84, 89, 1'b0, 1'b0, 2, 9'd138, -1};
        vecs[4] = '{9'd300, 16'hFF00, 16'h0800, 0, 83, 88, 1'b0, 1'b1, 0, 9'd300, 99};
        vecs[5] = '{9'd500, 16'h0042, 16'h0100, 1, 30, -1, 1'b0, 1'b1, 1, 9'd52,  40};
        vecs[6] = '{9'd256, 16'h7777, 16'h0001, 0, 90, -1, 1'b0, 1'b0, 2, 9'd384, -1};
        vecs[7] = '{9'd77,  16'h1357, 16'h2468, 0, 89, -1, 1'b0, 1'b1, 0, 9'd77,  99};

        resetn          = 1'b0;
        status          = 3'b000;
        req_valid       = 1'b0;
        req_init        = 9'd0;
        req_counter     = 16'd0;
        req_ref_counter = 16'd0;
        repeat (3) tick;
        check_reset_outputs("reset_initial");
        resetn = 1'b1;
        tick;
        check("idle_ready", {req_ready, busy, clk_resetn}, 3'b100);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Lock loss: a one-cycle drop is ignored, a two-cycle drop reloads with the same init.
        last_init = vecs[7].exp_init;
        lost_seen = 0;
        unlocked  = 0;
        status    = 3'b000;
        tick;
        status = LOCK;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (lock_lost) lost_seen++;
            if (!locked) unlocked++;
        end
        check("glitch_no_lost", lost_seen, 0);
        check("glitch_stay_locked", unlocked, 0);
        status = 3'b000;
        n      = 0;
        while (!lock_lost && n < 20) begin
            tick;
            n++;
        end
        check("lost_latency", n, 4);
        check("lost_state", {clk_resetn, busy, locked, retries, done, fail}, 8'b01000000);
        check("lost_same_init", init, last_init);
        $display("txn lock_lost init=%0d after %0d cycles", init, n);
        rv = '{last_init, vecs[7].cnt, vecs[7].rcnt, 0, 5, -1, 1'b0, 1'b1, 0, last_init, 15};
        push_exp(rv);
        monitor(rv);

        // Request held through the attempt is taken only once LOCKED.
        rv = '{9'd64, 16'h0010, 16'h0020, 0, 3, -1, 1'b1, 1'b1, 0, 9'd64, 13};
        run_vec(rv);

        status = 3'b000;
        repeat (6) tick;
        check("pre_reset_running", {clk_resetn, busy}, 2'b11);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        tick;
        tick;
        check_reset_outputs("reset_held");
        resetn = 1'b1;
        tick;
        check("post_reset_idle", {req_ready, busy, clk_resetn, locked}, 4'b1000);
        $display("txn async reset mid-attempt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
